// File: rtl/mm_line_arbiter.sv
// ---------------------------------------------------------------------------
// mm_line_arbiter
//
// Shares the single-port main memory between two line-burst requesters.
// Port 0 is the I-side miss path, port 1 is the D-side miss/writeback path.
// A grant is locked for a full line of BEATS words. The arbiter generates the
// per-word addresses and forwards mm_valid/mm_rdata to the granted port only.
//
// Configuration macro:
//   MM_ARB_RR_EN  defined   : round-robin on simultaneous requests
//                 undefined : fixed priority, port 1 always wins
//
// Parameters:
//   ADDR_W  byte address width
//   DATA_W  word width (multiple of 8)
//   BEATS   words per line (power of two, >= 2)
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   req*/we*/addr*/wdata*       per-port burst request, direction, line
//                               address and current write word
//   gnt*/valid*/rdata*/done*    per-port ownership, beat complete, read word
//                               and one-cycle end-of-burst pulse
//   mm_re/mm_we/mm_addr/mm_wdata  memory strobes, word address, write data
//   mm_rdata/mm_valid           memory read data and beat-complete
// ---------------------------------------------------------------------------
module mm_line_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              valid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              valid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              done1,
  output logic              mm_re,
  output logic              mm_we,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [DATA_W-1:0] mm_wdata,
  input  logic [DATA_W-1:0] mm_rdata,
  input  logic              mm_valid
);

  localparam int BYTES  = DATA_W / 8;
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = $clog2(BEATS * BYTES);
  // Clears the byte-within-line bits so every burst starts on a line boundary.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t              state, state_n;
  logic [BEAT_W-1:0]   beat, beat_n;
  logic                owner, owner_n;
  logic                we_l, we_n;
  logic [ADDR_W-1:0]   base, base_n;
  logic                pick;

`ifdef MM_ARB_RR_EN
  logic rr_last, rr_n;
  // On a tie the port that was not granted last wins.
  assign pick = (req0 && req1) ? ~rr_last : req1;
`else
  // Fixed priority: port 1 wins whenever it is requesting.
  assign pick = req1;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      beat    <= '0;
      owner   <= 1'b1;
      we_l    <= 1'b0;
      base    <= '0;
`ifdef MM_ARB_RR_EN
      rr_last <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      owner   <= owner_n;
      we_l    <= we_n;
      base    <= base_n;
`ifdef MM_ARB_RR_EN
      rr_last <= rr_n;
`endif
    end
  end

  // NOTE: every signal gets a hold default before the case so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    state_n = state;
    beat_n  = beat;
    owner_n = owner;
    we_n    = we_l;
    base_n  = base;
`ifdef MM_ARB_RR_EN
    rr_n    = rr_last;
`endif
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          owner_n = pick;
          we_n    = pick ? we1 : we0;
          base_n  = (pick ? addr1 : addr0) & LINE_MASK;
          beat_n  = '0;
          state_n = BURST;
`ifdef MM_ARB_RR_EN
          rr_n    = pick;
`endif
        end
      end
      BURST: begin
        // Requests are not looked at here: a burst cannot be aborted.
        if (mm_valid) begin
          beat_n = beat + BEAT_W'(1);  // BEATS is a power of two: wraps to 0
          if (beat == BEAT_W'(BEATS - 1)) state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  logic in_burst;
  logic beat_fire;

  assign in_burst  = (state == BURST);
  assign beat_fire = in_burst && mm_valid;

  assign gnt0     = in_burst && !owner;
  assign gnt1     = in_burst &&  owner;
  assign mm_re    = in_burst && !we_l;
  assign mm_we    = in_burst &&  we_l;
  assign mm_addr  = in_burst ? base + ADDR_W'(beat) * ADDR_W'(BYTES) : '0;
  assign mm_wdata = in_burst ? (owner ? wdata1 : wdata0) : '0;

  // Read data is gated so the non-owner, and the owner between beats, sees 0.
  assign valid0 = beat_fire && !owner;
  assign valid1 = beat_fire &&  owner;
  assign rdata0 = valid0 ? mm_rdata : '0;
  assign rdata1 = valid1 ? mm_rdata : '0;

  assign done0 = (state == DONE) && !owner;
  assign done1 = (state == DONE) &&  owner;

endmodule

// File: tb/tb_mm_line_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mm_line_arbiter
//
// Directed bench for mm_line_arbiter with default parameters (32-bit address
// and data, 4-beat lines). Inputs change 1 ns after the rising edge and
// outputs are sampled 3 ns later, well clear of the next edge.
// Expected values are hand-computed from the line address and beat index.
// ---------------------------------------------------------------------------
module tb_mm_line_arbiter;

  localparam int BEATS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, valid0, done0, gnt1, valid1, done1;
  logic [31:0] rdata0, rdata1;
  logic        mm_re, mm_we, mm_valid;
  logic [31:0] mm_addr, mm_wdata, mm_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mm_line_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .we0      (we0),
    .addr0    (addr0),
    .wdata0   (wdata0),
    .gnt0     (gnt0),
    .valid0   (valid0),
    .rdata0   (rdata0),
    .done0    (done0),
    .req1     (req1),
    .we1      (we1),
    .addr1    (addr1),
    .wdata1   (wdata1),
    .gnt1     (gnt1),
    .valid1   (valid1),
    .rdata1   (rdata1),
    .done1    (done1),
    .mm_re    (mm_re),
    .mm_we    (mm_we),
    .mm_addr  (mm_addr),
    .mm_wdata (mm_wdata),
    .mm_rdata (mm_rdata),
    .mm_valid (mm_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // Called in the first BURST cycle. Runs BEATS beats (with an optional
  // stall before beat 1), the DONE cycle and the following IDLE cycle.
  task automatic burst_check(input int p, input logic w, input logic [31:0] base,
                             input logic [31:0] d0, input int stall);
    logic [31:0] d;
    for (int b = 0; b < BEATS; b++) begin
      if (b == 1) begin
        for (int s = 0; s < stall; s++) begin
          mm_valid = 1'b0;
          settle();
          check("stall_gnt",   32'(p ? gnt1 : gnt0), 32'd1);
          check("stall_addr",  mm_addr, base + 32'd4);
          check("stall_valid", 32'(valid0 | valid1), 32'd0);
          tick();
        end
      end
      d        = d0 + 32'(b);
      mm_valid = 1'b1;
      mm_rdata = d;
      if (w) begin
        if (p == 1) wdata1 = d;
        else        wdata0 = d;
      end
      settle();
      check("burst_gnt",    32'(p ? gnt1 : gnt0), 32'd1);
      check("burst_gnt_nx", 32'(p ? gnt0 : gnt1), 32'd0);
      check("burst_addr",   mm_addr, base + 32'(4 * b));
      check("burst_re",     32'(mm_re), 32'(!w));
      check("burst_we",     32'(mm_we), 32'(w));
      check("burst_valid",  32'(p ? valid1 : valid0), 32'd1);
      check("burst_val_nx", 32'(p ? valid0 : valid1), 32'd0);
      check("burst_rd_nx",  p ? rdata0 : rdata1, 32'd0);
      if (w) check("burst_wdata", mm_wdata, d);
      else   check("burst_rdata", p ? rdata1 : rdata0, d);
      tick();
    end
    mm_valid = 1'b1;  // ignored outside BURST
    mm_rdata = 32'hDEAD;
    settle();
    check("done_pulse",   32'(p ? done1 : done0), 32'd1);
    check("done_nx",      32'(p ? done0 : done1), 32'd0);
    check("done_gnt",     32'(gnt0 | gnt1), 32'd0);
    check("done_strobe",  32'(mm_re | mm_we), 32'd0);
    check("done_valid",   32'(valid0 | valid1), 32'd0);
    tick();
    mm_valid = 1'b0;
    settle();
    check("idle_done",    32'(done0 | done1), 32'd0);
    check("idle_gnt",     32'(gnt0 | gnt1), 32'd0);
  endtask

  int win;

  initial begin
    reset = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    mm_valid = 1'b1; mm_rdata = 32'h55;
    tick();
    tick();
    settle();
    check("rst_gnt",   32'({gnt0, gnt1}), 32'd0);
    check("rst_valid", 32'({valid0, valid1}), 32'd0);
    check("rst_rdata", rdata0 | rdata1, 32'd0);
    check("rst_done",  32'({done0, done1}), 32'd0);
    check("rst_mm",    32'({mm_re, mm_we}), 32'd0);
    check("rst_addr",  mm_addr, 32'd0);
    check("rst_wdata", mm_wdata, 32'd0);
    reset    = 1'b0;
    mm_valid = 1'b0;
    tick();

    // Port-0 read from an unaligned address; done0 lands in cycle 6.
    req0 = 1'b1; addr0 = 32'h10C; we0 = 1'b0;
    settle();
    check("t1_idle_gnt", 32'(gnt0), 32'd0);
    tick();
    req0 = 1'b0;
    burst_check(0, 1'b0, 32'h100, 32'hA0, 0);
    tick();

    // Simultaneous requests: port 1 first, port 0 held and served next.
    req0 = 1'b1; addr0 = 32'h300; req1 = 1'b1; addr1 = 32'h400;
    tick();
    req1 = 1'b0;
    burst_check(1, 1'b0, 32'h400, 32'hB0, 0);
    tick();
    req0 = 1'b0;
    burst_check(0, 1'b0, 32'h300, 32'hB8, 0);
    tick();

    // Port-1 write; request-side changes during BURST must be ignored.
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'h2000;
    tick();
    req1 = 1'b0; we1 = 1'b0; addr1 = 32'hFFFF_FFF0;
    burst_check(1, 1'b1, 32'h2000, 32'hC0, 0);
    tick();

    // Tie after a port-1 grant: round-robin favours port 0.
`ifdef MM_ARB_RR_EN
    win = 0;
`else
    win = 1;
`endif
    req0 = 1'b1; addr0 = 32'h600; req1 = 1'b1; addr1 = 32'h700;
    tick();
    if (win == 1) req1 = 1'b0;
    else          req0 = 1'b0;
    burst_check(win, 1'b0, win ? 32'h700 : 32'h600, 32'hF0, 0);
    tick();
    req0 = 1'b0; req1 = 1'b0;
    burst_check(1 - win, 1'b0, win ? 32'h600 : 32'h700, 32'hF8, 0);
    tick();

    // Port-0 read with mm_valid stalled 3 cycles while beat 1 is pending.
    req0 = 1'b1; addr0 = 32'h100;
    tick();
    req0 = 1'b0;
    burst_check(0, 1'b0, 32'h100, 32'hD0, 3);
    tick();

    // Reset during beat 2 of a port-0 read.
    req0 = 1'b1; addr0 = 32'h104;
    tick();
    req0 = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mm_valid = 1'b1;
      mm_rdata = 32'h90 + 32'(b);
      tick();
    end
    mm_valid = 1'b0;
    settle();
    check("rb_addr", mm_addr, 32'h108);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("rb_gnt",  32'(gnt0 | gnt1), 32'd0);
    check("rb_done", 32'(done0 | done1), 32'd0);
    check("rb_mm",   32'(mm_re | mm_we), 32'd0);
    check("rb_addr0", mm_addr, 32'd0);
    tick();
    settle();
    check("rb_nodone", 32'(done0 | done1), 32'd0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h500;
    tick();
    req1 = 1'b0;
    burst_check(1, 1'b0, 32'h500, 32'hE0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mm_line_arbiter.md
Name: mm_line_arbiter

Overview:
- Arbitrates the single-port main memory between two line-burst requesters: port 0 is the I-side miss path (read only in practice); port 1 is the D-side miss/writeback path (read or write).
- Each grant is locked for a full cache-line burst of BEATS words. The arbiter generates per-word addresses and forwards mm_valid/mm_rdata back to the granted port.
- Sits between the cache controller's line-buffer sequencing and the main memory model.

Parameters:
- ADDR_W, 32, address width in bytes.
- DATA_W, 32, word width. Must be a multiple of 8.
- BEATS, 4, words per cache line. Must be a power of two and at least 2.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req0  in  1  port 0 burst request, level
- we0  in  1  port 0 write burst (1) or read burst (0)
- addr0  in  ADDR_W  port 0 line address
- wdata0  in  DATA_W  port 0 write word for the current beat
- gnt0  out  1  port 0 owns the memory
- valid0  out  1  port 0 beat complete
- rdata0  out  DATA_W  port 0 read word
- done0  out  1  port 0 burst finished, 1-cycle pulse
- req1, we1, addr1, wdata1, gnt1, valid1, rdata1, done1: same as port 0, for port 1
- mm_re  out  1  memory read strobe
- mm_we  out  1  memory write strobe
- mm_addr  out  ADDR_W  memory word address
- mm_wdata  out  DATA_W  memory write data
- mm_rdata  in  DATA_W  memory read data
- mm_valid  in  1  memory beat done

Behaviour:
- Reset: state=IDLE, beat=0, owner=1, rr_last=0. All outputs are 0: gnt*, valid*, done*, mm_re, mm_we, mm_addr, mm_wdata, rdata*.
- States: IDLE, BURST, DONE.
- IDLE:
  - No request: remain in IDLE.
  - One request: latch owner, that port's we, and its address with the low log2(BEATS*DATA_W/8) bits forced to 0. Clear beat. Go to BURST.
  - Both requests: port 1 wins by default; see Optional Feature.
- BURST:
  - gnt_owner=1. mm_re=~we_l and mm_we=we_l.
  - mm_addr = base + beat*(DATA_W/8), truncated to ADDR_W.
  - mm_wdata = wdata_owner, combinational; the requester advances its data on valid_owner.
  - On mm_valid: valid_owner=1 and rdata_owner=mm_rdata, both combinational in the same cycle. Then beat increments.
  - When mm_valid arrives with beat==BEATS-1: beat wraps to 0 and the next state is DONE.
  - If mm_valid stays low, hold all outputs and stay in BURST indefinitely, with no timeout.
- DONE: done_owner=1 for exactly one cycle. gnt and mm strobes are 0. Next state is IDLE.
- Minimum burst length: 1 cycle in IDLE + BEATS cycles in BURST + 1 cycle in DONE. Re-arbitration is possible in the cycle after DONE.
- Outputs never go to the non-owner port: the non-owner's gnt, valid, rdata and done are all 0. Its rdata is 0 whenever its valid is 0.
- Request changes during BURST (req drop, new address, we toggle) are ignored. Bursts cannot be aborted.
- mm_valid is ignored in IDLE and DONE.
- If a requester holds req high through DONE, the arbiter sees it in IDLE and treats it as a new request.
- A synchronous reset during BURST returns to IDLE immediately. The partial burst is dropped and no done pulse is issued.

Optional Feature:
- Macro: MM_ARB_RR_EN.
- Defined: round-robin arbitration on simultaneous requests. The port not granted last wins. rr_last updates on entry to BURST.
- Not defined: fixed priority, port 1 (D-side) always wins. rr_last is not implemented.

Test Plan:
- Port-0 read, addr0=0x10C, mm_valid high every cycle, mm_rdata=0xA0..0xA3.
  - mm_addr must step 0x100, 0x104, 0x108, 0x10C.
  - valid0 pulses 4 times with matching rdata0.
  - done0 is high in cycle 6 after req0. gnt1, valid1 and done1 stay 0.
- req0 and req1 asserted in the same cycle, fixed priority.
  - Port 1's full burst runs first, then port 0's.
  - With MM_ARB_RR_EN and rr_last=1, port 0 goes first.
- Port-1 write, addr1=0x2000, wdata1 advanced on each valid1.
  - mm_we=1 and mm_re=0 throughout BURST. mm_wdata must match the 4 supplied words in order.
- mm_valid stalled 3 cycles between beats 1 and 2.
  - mm_addr holds 0x104 and gnt stays high. No extra valid pulses. Burst completes correctly.
- reset asserted during beat 2 of a port-0 read.
  - The next cycle shows IDLE with all outputs 0 and no done0.
  - A new req1 is then served starting from beat 0.
